// File: rtl/clip_sequencer.sv
// Record/play sequencer for two clip memories: turns start/stop commands and
// sample pacing strobes into registered per-clip address, enable and write strobes.
module clip_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_record_i,
    input  logic              start_play_i,
    input  logic              stop_i,
    input  logic              clip_i,
    input  logic              sample_valid_i,
    input  logic              sample_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem0_en_o,
    output logic              mem0_we_o,
    output logic              mem1_en_o,
    output logic              mem1_we_o,
    output logic              recording_o,
    output logic              playing_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   clip0_len_o,
    output logic [ADDR_W:0]   clip1_len_o
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              sel_reg, sel_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  len_reg [0:1];
    logic [CNT_W-1:0]  len_next [0:1];
    logic [CNT_W-1:0]  cur_len;
    logic [ADDR_W-1:0] addr_reg;
    logic              en_reg [0:1];
    logic              we_reg [0:1];
    logic              error_reg, error_next;
    logic              strobe;
    logic              write;

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        count_next = count_reg;
        len_next   = len_reg;
        error_next = 1'b0;
        strobe     = 1'b0;
        write      = 1'b0;
        cur_len    = len_reg[sel_reg];

        case (state_reg)
            IDLE: begin
                if (start_record_i) begin
                    state_next       = RECORD;
                    sel_next         = clip_i;
                    count_next       = '0;
                    len_next[clip_i] = '0;
                end else if (start_play_i) begin
                    if (len_reg[clip_i] == '0) begin
                        error_next = 1'b1;
                    end else begin
                        state_next = PLAY;
                        sel_next   = clip_i;
                        count_next = '0;
                    end
                end
            end
            RECORD: begin
                if (sample_valid_i && (count_reg != DEPTH)) begin
                    strobe     = 1'b1;
                    write      = 1'b1;
                    count_next = count_reg + ONE;
                end
                // A write coinciding with stop is counted before the length is latched.
                if (stop_i || (strobe && (count_next == DEPTH))) begin
                    state_next        = DONE;
                    len_next[sel_reg] = count_next;
                end
            end
            PLAY: begin
                if (sample_ready_i && (count_reg < cur_len)) begin
                    strobe     = 1'b1;
                    count_next = count_reg + ONE;
                end
                if (stop_i || (strobe && (count_next == cur_len))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg  <= IDLE;
            sel_reg    <= 1'b0;
            count_reg  <= '0;
            len_reg[0] <= '0;
            len_reg[1] <= '0;
            addr_reg   <= '0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            count_reg  <= count_next;
            len_reg[0] <= len_next[0];
            len_reg[1] <= len_next[1];
            error_reg  <= error_next;
            if (strobe) begin
                addr_reg <= count_reg[ADDR_W-1:0];
            end
        end
    end

    // Only the selected clip memory ever sees a strobe.
    for (genvar gi = 0; gi < 2; gi++) begin : g_clip
        always_ff @(posedge clock_i or negedge reset_i) begin
            if (!reset_i) begin
                en_reg[gi] <= 1'b0;
                we_reg[gi] <= 1'b0;
            end else begin
                en_reg[gi] <= strobe && (sel_reg == 1'(gi));
                we_reg[gi] <= write && (sel_reg == 1'(gi));
            end
        end
    end

    assign mem_addr_o  = addr_reg;
    assign mem0_en_o   = en_reg[0];
    assign mem0_we_o   = we_reg[0];
    assign mem1_en_o   = en_reg[1];
    assign mem1_we_o   = we_reg[1];
    assign recording_o = (state_reg == RECORD);
    assign playing_o   = (state_reg == PLAY);
    assign done_o      = (state_reg == DONE);
    assign error_o     = error_reg;
    assign clip0_len_o = len_reg[0];
    assign clip1_len_o = len_reg[1];

endmodule

// File: tb/tb_clip_sequencer.sv
// Directed bench for clip_sequencer: a full-size instance for record/play/error
// cases and a 3-bit-address instance for the depth-limit auto stop.
module tb_clip_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Instance A: ADDR_W = 16
    logic a_start_rec = 0, a_start_play = 0, a_stop = 0, a_clip = 0, a_valid = 0, a_ready = 0;
    logic [15:0] a_addr;
    logic a_en0, a_we0, a_en1, a_we1, a_rec, a_play, a_done, a_err;
    logic [16:0] a_len0, a_len1;

    // Instance B: ADDR_W = 3
    logic b_start_rec = 0, b_start_play = 0, b_stop = 0, b_clip = 0, b_valid = 0, b_ready = 0;
    logic [2:0] b_addr;
    logic b_en0, b_we0, b_en1, b_we1, b_rec, b_play, b_done, b_err;
    logic [3:0] b_len0, b_len1;

    clip_sequencer #(.ADDR_W(16)) dut_a (
        .clock_i(clk), .reset_i(rst_n),
        .start_record_i(a_start_rec), .start_play_i(a_start_play), .stop_i(a_stop),
        .clip_i(a_clip), .sample_valid_i(a_valid), .sample_ready_i(a_ready),
        .mem_addr_o(a_addr), .mem0_en_o(a_en0), .mem0_we_o(a_we0),
        .mem1_en_o(a_en1), .mem1_we_o(a_we1), .recording_o(a_rec), .playing_o(a_play),
        .done_o(a_done), .error_o(a_err), .clip0_len_o(a_len0), .clip1_len_o(a_len1)
    );

    clip_sequencer #(.ADDR_W(3)) dut_b (
        .clock_i(clk), .reset_i(rst_n),
        .start_record_i(b_start_rec), .start_play_i(b_start_play), .stop_i(b_stop),
        .clip_i(b_clip), .sample_valid_i(b_valid), .sample_ready_i(b_ready),
        .mem_addr_o(b_addr), .mem0_en_o(b_en0), .mem0_we_o(b_we0),
        .mem1_en_o(b_en1), .mem1_we_o(b_we1), .recording_o(b_rec), .playing_o(b_play),
        .done_o(b_done), .error_o(b_err), .clip0_len_o(b_len0), .clip1_len_o(b_len1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; pulse inputs set beforehand are sampled there, then cleared.
    task automatic step();
        @(posedge clk);
        #1;
        a_start_rec = 0; a_start_play = 0; a_stop = 0; a_valid = 0; a_ready = 0;
        b_start_rec = 0; b_start_play = 0; b_stop = 0; b_valid = 0; b_ready = 0;
    endtask

    task automatic check_a_quiet(input string tag);
        check({tag, "_addr"}, 32'(a_addr), 0);
        check({tag, "_en0"}, 32'(a_en0), 0);
        check({tag, "_we0"}, 32'(a_we0), 0);
        check({tag, "_en1"}, 32'(a_en1), 0);
        check({tag, "_rec"}, 32'(a_rec), 0);
        check({tag, "_play"}, 32'(a_play), 0);
        check({tag, "_done"}, 32'(a_done), 0);
        check({tag, "_err"}, 32'(a_err), 0);
        check({tag, "_len0"}, 32'(a_len0), 0);
        check({tag, "_len1"}, 32'(a_len1), 0);
    endtask

    initial begin
        repeat (3) step();
        check_a_quiet("reset");
        rst_n = 1'b1;
        step();

        // 1: reset in the middle of a clip 0 recording
        a_start_rec = 1; a_clip = 0; step();
        check("t1_rec", 32'(a_rec), 1);
        for (int i = 0; i < 3; i++) begin
            a_valid = 1; step();
        end
        check("t1_addr_before", 32'(a_addr), 2);
        rst_n = 1'b0;
        #1;
        check_a_quiet("t1_async");
        step();
        check_a_quiet("t1_next");
        rst_n = 1'b1;
        step();

        // 2: record clip 0, five samples then stop
        a_start_rec = 1; a_clip = 0; step();
        check("t2_rec", 32'(a_rec), 1);
        check("t2_len0_clr", 32'(a_len0), 0);
        for (int i = 0; i < 5; i++) begin
            a_valid = 1; step();
            check($sformatf("t2_wr%0d_en0", i), 32'(a_en0), 1);
            check($sformatf("t2_wr%0d_we0", i), 32'(a_we0), 1);
            check($sformatf("t2_wr%0d_addr", i), 32'(a_addr), 32'(i));
            check($sformatf("t2_wr%0d_en1", i), 32'(a_en1), 0);
            step();
            check($sformatf("t2_gap%0d_en0", i), 32'(a_en0), 0);
            check($sformatf("t2_gap%0d_addr_hold", i), 32'(a_addr), 32'(i));
        end
        a_stop = 1; step();
        check("t2_done", 32'(a_done), 1);
        check("t2_rec_off", 32'(a_rec), 0);
        check("t2_len0", 32'(a_len0), 5);
        check("t2_en0_stop", 32'(a_en0), 0);
        step();
        check("t2_done_once", 32'(a_done), 0);

        // 3: play clip 0 back, one surplus request at the end
        a_start_play = 1; a_clip = 0; step();
        check("t3_play", 32'(a_play), 1);
        for (int i = 0; i < 5; i++) begin
            a_ready = 1; step();
            check($sformatf("t3_rd%0d_en0", i), 32'(a_en0), 1);
            check($sformatf("t3_rd%0d_we0", i), 32'(a_we0), 0);
            check($sformatf("t3_rd%0d_addr", i), 32'(a_addr), 32'(i));
            check($sformatf("t3_rd%0d_done", i), 32'(a_done), (i == 4) ? 1 : 0);
            check($sformatf("t3_rd%0d_en1", i), 32'(a_en1), 0);
        end
        step();
        check("t3_idle_done", 32'(a_done), 0);
        a_ready = 1; step();
        check("t3_extra_en0", 32'(a_en0), 0);
        check("t3_extra_play", 32'(a_play), 0);
        check("t3_len0_kept", 32'(a_len0), 5);

        // 5: play an empty clip 1
        a_start_play = 1; a_clip = 1; step();
        check("t5_err", 32'(a_err), 1);
        check("t5_play", 32'(a_play), 0);
        check("t5_en1", 32'(a_en1), 0);
        step();
        check("t5_err_pulse", 32'(a_err), 0);
        check("t5_play_after", 32'(a_play), 0);

        // 6: both starts together, then stop coinciding with a sample
        a_start_rec = 1; a_start_play = 1; a_clip = 1; step();
        check("t6_rec", 32'(a_rec), 1);
        check("t6_play", 32'(a_play), 0);
        a_valid = 1; step();
        a_valid = 1; step();
        check("t6_addr1", 32'(a_addr), 1);
        a_valid = 1; a_stop = 1; step();
        check("t6_en1", 32'(a_en1), 1);
        check("t6_we1", 32'(a_we1), 1);
        check("t6_addr2", 32'(a_addr), 2);
        check("t6_en0", 32'(a_en0), 0);
        check("t6_done", 32'(a_done), 1);
        check("t6_len1", 32'(a_len1), 3);
        check("t6_len0", 32'(a_len0), 5);
        step();

        // 4: ADDR_W = 3, nine back-to-back samples into clip 1
        b_start_rec = 1; b_clip = 1; step();
        check("t4_rec", 32'(b_rec), 1);
        for (int k = 0; k < 9; k++) begin
            b_valid = 1; step();
            if (k < 8) begin
                check($sformatf("t4_wr%0d_en1", k), 32'(b_en1), 1);
                check($sformatf("t4_wr%0d_we1", k), 32'(b_we1), 1);
                check($sformatf("t4_wr%0d_addr", k), 32'(b_addr), 32'(k));
            end else begin
                check("t4_ninth_en1", 32'(b_en1), 0);
                check("t4_ninth_addr_hold", 32'(b_addr), 7);
            end
            check($sformatf("t4_wr%0d_en0", k), 32'(b_en0), 0);
            check($sformatf("t4_wr%0d_done", k), 32'(b_done), (k == 7) ? 1 : 0);
        end
        check("t4_len1", 32'(b_len1), 8);
        check("t4_rec_off", 32'(b_rec), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
